if_fetch_unit: RTL

- Instruction fetch stage. Owns the PC, issues single-outstanding requests to instruction memory, and drives the instruction/address pair consumed by the IF/ID pipeline register.
- Handles stall from the hazard unit and redirect (taken branch/jump) from EX.
- Stale responses are discarded after a redirect.
- Bubbles are presented as all-zero instruction and address, matching the IF/ID flush value.

---
 rtl/if_fetch_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time, feeds IF/ID.
// Latency: request accepted at t, response at t+k (k>=1), instruction valid at IF/ID output at t+k+1.
// Backpressure: stall holds the output and blocks new requests; imem_ready gates request acceptance.
// Optional response watchdog and FAULT state enabled by defining IFETCH_TIMEOUT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_address,
    output logic        instr_valid,
    output logic        fetch_fault
);

    // DRAIN means a request is in flight whose response must be thrown away.
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN, S_FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic        vld_q, vld_d;

    logic        req;
    logic        handshake;
    logic        capture;
    logic        timeout;
    logic [31:0] redirect_tgt;
    logic        unused_redirect_lsbs;

    // Instructions are word aligned; the low target bits carry no information.
    assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign req       = (state_q == S_FETCH) && !stall;
    assign handshake = req && imem_ready;
    assign capture   = (state_q == S_WAIT) && imem_rvalid && !redirect;

`ifdef IFETCH_TIMEOUT_EN
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        fault_q, fault_d;
    logic        waiting;

    assign waiting = (state_q == S_WAIT) || (state_q == S_DRAIN);
    // Expire on the TIMEOUT_CYCLES-th consecutive waiting cycle without a response; redirect wins.
    assign timeout = waiting && !imem_rvalid && !redirect && (wait_cnt_q == WAIT_LIMIT);

    // Watchdog count: restarts on entry to WAIT/DRAIN or on a response, counts while waiting.
    always_comb begin
        wait_cnt_d = '0;
        if (waiting && (state_d == state_q) && !imem_rvalid) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    // Sticky fault flag, cleared only by a redirect out of FAULT (or reset).
    always_comb begin
        fault_d = fault_q;
        if ((state_q == S_FAULT) && redirect) begin
            fault_d = 1'b0;
        end else if (timeout) begin
            fault_d = 1'b1;
        end
    end

    // Watchdog state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    assign fetch_fault = fault_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
    assign fetch_fault        = 1'b0;
`endif

    // State register plus PC and IF/ID output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
        end
    end

    // Next-state: track the single outstanding request and whether its response is still wanted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (handshake) begin
                    state_d = redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                end else if (redirect) begin
                    state_d = S_DRAIN;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_DRAIN: begin
                // The stale response ends the drain even if another redirect lands with it.
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                if (redirect) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // PC and output datapath: redirect flushes, capture loads, any unstalled cycle consumes.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        vld_d   = vld_q;
        if (redirect) begin
            pc_d    = redirect_tgt;
            instr_d = '0;
            addr_d  = '0;
            vld_d   = 1'b0;
        end else if (capture) begin
            instr_d = imem_rdata;
            addr_d  = pc_q;
            vld_d   = 1'b1;
            pc_d    = pc_q + 32'd4;
        end else if (!stall || (state_q == S_FAULT)) begin
            instr_d = '0;
            addr_d  = '0;
            vld_d   = 1'b0;
        end
    end

    // Outputs come straight from registered state (and stall for the request).
    always_comb begin
        imem_req      = req;
        imem_addr     = pc_q;
        instruction   = instr_q;
        instr_address = addr_q;
        instr_valid   = vld_q;
    end

endmodule
